// File: rtl/p2p_pkg.sv
// rtl/p2p_pkg.sv - register map, response codes and decode helpers for the p2p control registers
package p2p_pkg;

    localparam int ADDR_LSB     = 2;
    localparam int ADDR_W       = 10;
    localparam int CNT_W        = 32;
    localparam int BLOCK_TX_LSB = 8;

    localparam logic [31:0] REG_ID_DEFAULT = 32'h5032_5001;

    // Word indexes, i.e. byte offset >> 2
    localparam logic [ADDR_W-1:0] OFF_ID          = 10'h000;
    localparam logic [ADDR_W-1:0] OFF_CTRL        = 10'h001;
    localparam logic [ADDR_W-1:0] OFF_SCRATCH     = 10'h002;
    localparam logic [ADDR_W-1:0] OFF_CNT_CLR     = 10'h003;
    localparam logic [ADDR_W-1:0] OFF_RX_CNT      = 10'h040;
    localparam logic [ADDR_W-1:0] OFF_DROP_CNT    = 10'h041;
    localparam logic [ADDR_W-1:0] OFF_PORT_STRIDE = 10'h004;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [ADDR_W-1:0] port_off(input logic [ADDR_W-1:0] base, input int port);
        return base + OFF_PORT_STRIDE * ADDR_W'(port);
    endfunction

endpackage

// File: rtl/p2p_sat_counter.sv
// rtl/p2p_sat_counter.sv - saturating event counter with synchronous clear
module p2p_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Clear has priority over a coincident increment
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/p2p_axil_regs.sv
// rtl/p2p_axil_regs.sv - AXI4-Lite control/status registers for the p2p plugin
module p2p_axil_regs
    import p2p_pkg::*;
#(
    parameter int          NUM_CMAC_PORT = 2,
    parameter logic [31:0] REG_ID        = REG_ID_DEFAULT
) (
    input  logic                     axil_aclk,
    input  logic                     axil_aresetn,
    input  logic                     s_axil_awvalid,
    input  logic [31:0]              s_axil_awaddr,
    output logic                     s_axil_awready,
    input  logic                     s_axil_wvalid,
    input  logic [31:0]              s_axil_wdata,
    output logic                     s_axil_wready,
    output logic                     s_axil_bvalid,
    output logic [1:0]               s_axil_bresp,
    input  logic                     s_axil_bready,
    input  logic                     s_axil_arvalid,
    input  logic [31:0]              s_axil_araddr,
    output logic                     s_axil_arready,
    output logic                     s_axil_rvalid,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    input  logic                     s_axil_rready,
    input  logic [NUM_CMAC_PORT-1:0] rx_pkt_pulse,
    input  logic [NUM_CMAC_PORT-1:0] drop_pkt_pulse,
    output logic [NUM_CMAC_PORT-1:0] block_rx,
    output logic [NUM_CMAC_PORT-1:0] block_tx
);

    localparam int N = NUM_CMAC_PORT;

    logic              r_awready, r_wready, r_arready;
    logic              r_aw_held, r_w_held;
    logic [ADDR_W-1:0] r_aw_idx;
    logic [31:0]       r_wdata;
    logic              r_bvalid, r_rvalid;
    logic [1:0]        r_bresp, r_rresp;
    logic [31:0]       r_rdata;
    logic [N-1:0]      r_ctrl_rx, r_ctrl_tx;
    logic [N-1:0]      r_block_rx, r_block_tx;
    logic [31:0]       r_scratch;

    logic              w_aw_fire, w_w_fire, w_ar_fire, w_wr_exec;
    logic              w_aw_held_nxt, w_w_held_nxt, w_bvalid_nxt, w_rvalid_nxt;
    logic              w_wr_err, w_rd_err;
    logic [ADDR_W-1:0] w_ar_idx;
    logic [31:0]       w_rd_data;
    logic [N-1:0]      w_cnt_clr;
    logic [CNT_W-1:0]  w_rx_cnt   [N];
    logic [CNT_W-1:0]  w_drop_cnt [N];
    logic              w_unused_addr;

    assign w_ar_idx      = s_axil_araddr[ADDR_LSB +: ADDR_W];
    assign w_unused_addr = ^{s_axil_awaddr[31:ADDR_LSB+ADDR_W], s_axil_awaddr[ADDR_LSB-1:0],
                             s_axil_araddr[31:ADDR_LSB+ADDR_W], s_axil_araddr[ADDR_LSB-1:0]};

    // A write executes once both halves have been captured in earlier cycles
    assign w_aw_fire     = s_axil_awvalid && r_awready;
    assign w_w_fire      = s_axil_wvalid && r_wready;
    assign w_wr_exec     = r_aw_held && r_w_held;
    assign w_aw_held_nxt = !w_wr_exec && (r_aw_held || w_aw_fire);
    assign w_w_held_nxt  = !w_wr_exec && (r_w_held || w_w_fire);
    assign w_bvalid_nxt  = w_wr_exec || (r_bvalid && !s_axil_bready);
    assign w_ar_fire     = s_axil_arvalid && r_arready;
    assign w_rvalid_nxt  = w_ar_fire || (r_rvalid && !s_axil_rready);

    assign w_wr_err  = !((r_aw_idx == OFF_CTRL) || (r_aw_idx == OFF_SCRATCH) || (r_aw_idx == OFF_CNT_CLR));
    assign w_cnt_clr = (w_wr_exec && (r_aw_idx == OFF_CNT_CLR)) ? r_wdata[N-1:0] : '0;

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (w_ar_idx)
            OFF_ID:      w_rd_data = REG_ID;
            OFF_CTRL: begin
                w_rd_data[N-1:0]            = r_ctrl_rx;
                w_rd_data[BLOCK_TX_LSB +: N] = r_ctrl_tx;
            end
            OFF_SCRATCH: w_rd_data = r_scratch;
            OFF_CNT_CLR: w_rd_data = '0;
            default:     w_rd_err  = 1'b1;
        endcase
        for (int i = 0; i < N; i++) begin
            if (w_ar_idx == port_off(OFF_RX_CNT, i)) begin
                w_rd_data = w_rx_cnt[i];
                w_rd_err  = 1'b0;
            end
            if (w_ar_idx == port_off(OFF_DROP_CNT, i)) begin
                w_rd_data = w_drop_cnt[i];
                w_rd_err  = 1'b0;
            end
        end
    end

    always_ff @(posedge axil_aclk) begin
        if (!axil_aresetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_awready <= !w_aw_held_nxt && !w_bvalid_nxt;
            r_wready  <= !w_w_held_nxt && !w_bvalid_nxt;
            if (w_aw_fire) r_aw_idx <= s_axil_awaddr[ADDR_LSB +: ADDR_W];
            if (w_w_fire)  r_wdata  <= s_axil_wdata;
            if (w_wr_exec) r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge axil_aclk) begin
        if (!axil_aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= !w_rvalid_nxt;
            if (w_ar_fire) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge axil_aclk) begin
        if (!axil_aresetn) begin
            r_ctrl_rx  <= '0;
            r_ctrl_tx  <= '0;
            r_scratch  <= '0;
            r_block_rx <= '0;
            r_block_tx <= '0;
        end else begin
            if (w_wr_exec && (r_aw_idx == OFF_CTRL)) begin
                r_ctrl_rx <= r_wdata[N-1:0];
                r_ctrl_tx <= r_wdata[BLOCK_TX_LSB +: N];
            end
            if (w_wr_exec && (r_aw_idx == OFF_SCRATCH)) r_scratch <= r_wdata;
            r_block_rx <= r_ctrl_rx;
            r_block_tx <= r_ctrl_tx;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_port
        p2p_sat_counter #(.WIDTH(CNT_W)) u_rx_cnt (
            .i_clk    (axil_aclk),
            .i_resetn (axil_aresetn),
            .i_inc    (rx_pkt_pulse[gi]),
            .i_clr    (w_cnt_clr[gi]),
            .o_count  (w_rx_cnt[gi])
        );
        p2p_sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
            .i_clk    (axil_aclk),
            .i_resetn (axil_aresetn),
            .i_inc    (drop_pkt_pulse[gi]),
            .i_clr    (w_cnt_clr[gi]),
            .o_count  (w_drop_cnt[gi])
        );
    end

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_wready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;
    assign block_rx       = r_block_rx;
    assign block_tx       = r_block_tx;

endmodule

// File: tb/tb_p2p_axil_regs.sv
// tb/tb_p2p_axil_regs.sv - directed self-checking bench for p2p_axil_regs
module tb_p2p_axil_regs;

    localparam int N = 2;
    localparam logic [31:0] EXP_ID = 32'h5032_5001;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [N-1:0] rx_pulse = '0, drop_pulse = '0;
    logic [N-1:0] block_rx, block_tx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    p2p_axil_regs #(.NUM_CMAC_PORT(N), .REG_ID(EXP_ID)) dut (
        .axil_aclk      (clk),
        .axil_aresetn   (resetn),
        .s_axil_awvalid (awvalid),
        .s_axil_awaddr  (awaddr),
        .s_axil_awready (awready),
        .s_axil_wvalid  (wvalid),
        .s_axil_wdata   (wdata),
        .s_axil_wready  (wready),
        .s_axil_bvalid  (bvalid),
        .s_axil_bresp   (bresp),
        .s_axil_bready  (bready),
        .s_axil_arvalid (arvalid),
        .s_axil_araddr  (araddr),
        .s_axil_arready (arready),
        .s_axil_rvalid  (rvalid),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rready  (rready),
        .rx_pkt_pulse   (rx_pulse),
        .drop_pkt_pulse (drop_pulse),
        .block_rx       (block_rx),
        .block_tx       (block_tx)
    );

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(negedge clk); n++;
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bvalid);
        end
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1; n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
        end
        d = rdata; resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_handshake got=%b required 00000", {awready, wready, arready, bvalid, rvalid});
        end
        n_checks++;
        if ({rdata, rresp, bresp, block_rx, block_tx} !== '0) begin
            n_fail++; $display("FAIL reset_data rdata=%h rresp=%b bresp=%b brx=%b btx=%b required all 0", rdata, rresp, bresp, block_rx, block_tx);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++; $display("FAIL ready_after_reset got=%b required 111", {awready, wready, arready});
        end
        araddr = 32'h0; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== EXP_ID || rresp !== 2'b00) begin
            n_fail++; $display("FAIL id_read rvalid=%b rdata=%h rresp=%b required 1 %h 00", rvalid, rdata, rresp, EXP_ID);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rvalid_drop got=%b required 0", rvalid);
        end
    endtask

    task automatic test_ctrl_split;
        logic [31:0] d; logic [1:0] r;
        @(negedge clk);
        awaddr = 32'h4; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        @(negedge clk);
        wdata = 32'h0000_0101; wvalid = 1'b1;
        n_checks++;
        if (wready !== 1'b1 || awready !== 1'b0) begin
            n_fail++; $display("FAIL split_ready wready=%b awready=%b required 1 0", wready, awready);
        end
        @(negedge clk);
        wvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_fail++; $display("FAIL split_bresp bvalid=%b bresp=%b required 1 00", bvalid, bresp);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (block_rx !== 2'b01 || block_tx !== 2'b01) begin
            n_fail++; $display("FAIL block_out rx=%b tx=%b required 01 01", block_rx, block_tx);
        end
        axi_read(32'h4, d, r);
        n_checks++;
        if (d !== 32'h0000_0101 || r !== 2'b00) begin
            n_fail++; $display("FAIL ctrl_read got=%h/%b required 00000101/00", d, r);
        end
    endtask

    task automatic test_errors;
        logic [31:0] d; logic [1:0] r;
        axi_write(32'h0, 32'h0000_FFFF, r);
        n_checks++;
        if (r !== 2'b10) begin n_fail++; $display("FAIL ro_write_bresp got=%b required 10", r); end
        axi_read(32'h1, d, r);
        n_checks++;
        if (d !== EXP_ID || r !== 2'b00) begin
            n_fail++; $display("FAIL id_unchanged got=%h/%b required %h/00", d, r, EXP_ID);
        end
        axi_read(32'h200, d, r);
        n_checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            n_fail++; $display("FAIL unmapped_read got=%h/%b required 00000000/10", d, r);
        end
        axi_write(32'h0000_100B, 32'hA5A5_5A5A, r);
        n_checks++;
        if (r !== 2'b00) begin n_fail++; $display("FAIL scratch_alias_bresp got=%b required 00", r); end
        axi_read(32'h8, d, r);
        n_checks++;
        if (d !== 32'hA5A5_5A5A || r !== 2'b00) begin
            n_fail++; $display("FAIL scratch_read got=%h/%b required a5a55a5a/00", d, r);
        end
        axi_write(32'h120, 32'h1, r);
        n_checks++;
        if (r !== 2'b10) begin n_fail++; $display("FAIL cnt_port2_write got=%b required 10", r); end
    endtask

    task automatic test_bready_stall;
        logic [31:0] d; logic [1:0] r;
        int bad = 0;
        @(negedge clk);
        awaddr = 32'h8; wdata = 32'h0000_1234; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n_checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++; $display("FAIL stall_pre awready=%b wready=%b required 1 1", awready, wready);
        end
        @(negedge clk);
        wdata = 32'h0000_5678;
        @(negedge clk);
        repeat (5) begin
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL stall_hold bad_cycles=%0d required 0", bad);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release bvalid=%b awready=%b wready=%b required 0 1 1", bvalid, awready, wready);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_fail++; $display("FAIL second_write bvalid=%b bresp=%b required 1 00", bvalid, bresp);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        axi_read(32'h8, d, r);
        n_checks++;
        if (d !== 32'h0000_5678) begin n_fail++; $display("FAIL stall_scratch got=%h required 00005678", d); end
    endtask

    task automatic test_rw_same_cycle;
        logic [31:0] d; logic [1:0] r;
        @(negedge clk);
        awaddr = 32'h4; wdata = 32'h0000_0202; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h4; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h0000_0101 || bvalid !== 1'b1) begin
            n_fail++; $display("FAIL same_cycle rvalid=%b rdata=%h bvalid=%b required 1 00000101 1", rvalid, rdata, bvalid);
        end
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        axi_read(32'h4, d, r);
        n_checks++;
        if (d !== 32'h0000_0202 || block_rx !== 2'b10 || block_tx !== 2'b10) begin
            n_fail++; $display("FAIL ctrl_after got=%h brx=%b btx=%b required 00000202 10 10", d, block_rx, block_tx);
        end
    endtask

    task automatic test_cnt_clear;
        logic [31:0] d; logic [1:0] r;
        @(negedge clk);
        rx_pulse = 2'b11; drop_pulse = 2'b10;
        @(negedge clk);
        rx_pulse = 2'b00; drop_pulse = 2'b00;
        @(negedge clk);
        rx_pulse = 2'b10;
        @(negedge clk);
        rx_pulse = 2'b00;
        awaddr = 32'hC; wdata = 32'h0000_0002; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; rx_pulse = 2'b10;
        @(negedge clk);
        rx_pulse = 2'b00;
        n_checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_fail++; $display("FAIL clr_bresp bvalid=%b bresp=%b required 1 00", bvalid, bresp);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        axi_read(32'h110, d, r);
        n_checks++;
        if (d !== 32'h0 || r !== 2'b00) begin n_fail++; $display("FAIL rx1_cleared got=%h/%b required 00000000/00", d, r); end
        axi_read(32'h114, d, r);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL drop1_cleared got=%h required 00000000", d); end
        axi_read(32'h100, d, r);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL rx0_kept got=%h required 00000001", d); end
        @(negedge clk);
        rx_pulse = 2'b10;
        repeat (2) @(negedge clk);
        rx_pulse = 2'b00;
        axi_read(32'h110, d, r);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL rx1_recount got=%h required 00000002", d); end
        axi_read(32'hC, d, r);
        n_checks++;
        if (d !== 32'h0 || r !== 2'b00) begin n_fail++; $display("FAIL cnt_clr_read got=%h/%b required 00000000/00", d, r); end
    endtask

    task automatic test_saturate_reset;
        logic [31:0] d; logic [1:0] r;
        @(negedge clk);
        dut.g_port[0].u_rx_cnt.r_count = 32'hFFFF_FFFE;
        rx_pulse = 2'b01;
        repeat (3) @(negedge clk);
        rx_pulse = 2'b00;
        axi_read(32'h100, d, r);
        n_checks++;
        if (d !== 32'hFFFF_FFFF || r !== 2'b00) begin
            n_fail++; $display("FAIL saturate got=%h/%b required ffffffff/00", d, r);
        end
        @(negedge clk);
        araddr = 32'h100; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1) begin n_fail++; $display("FAIL midread_rvalid got=%b required 1", rvalid); end
        resetn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0 || arready !== 1'b0 || block_rx !== 2'b00) begin
            n_fail++; $display("FAIL abort_read rvalid=%b rdata=%h arready=%b brx=%b required 0 00000000 0 00", rvalid, rdata, arready, block_rx);
        end
        resetn = 1'b1;
        axi_read(32'h100, d, r);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL cnt_after_reset got=%h required 00000000", d); end
    endtask

    initial begin
        test_reset();
        test_ctrl_split();
        test_errors();
        test_bready_stall();
        test_rw_same_cycle();
        test_cnt_clear();
        test_saturate_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required finish before 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
